cm0_dap_cdc_recv_ctrl: RTL and testbench

//  Receive-side controller for a 32-bit four-phase req/ack CDC data crossing in the DAP.
//  - Synchronises the remote REQ and drives MASKn to the downstream-glitch-free AND mask.
//  - Captures the masked word into a 1-deep output register and returns ACK to the sender.
//  - Presents the word to the local consumer with a valid/ready handshake.

---
 rtl/cm0_dap_cdc_pkg.sv | 25 ++
 rtl/cm0_dap_cdc_sync_ff.sv | 25 ++
 rtl/cm0_dap_cdc_recv_ctrl.sv | 143 ++++++++++++++
 tb/tb_cm0_dap_cdc_recv_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm0_dap_cdc_pkg.sv
// Shared types and limits for the DAP receive-side req/ack CDC crossing.
package cm0_dap_cdc_pkg;

    localparam int CDC_DATA_W      = 32;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 3;
    localparam int SETTLE_MIN      = 1;
    localparam int SETTLE_MAX      = 3;
    localparam int SETTLE_CNT_W    = 2;

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        CAPT,
        ACKHI,
        ACKLO
    } cdc_state_e;

    // Even parity over data plus parity bit: 1 means the word arrived corrupted.
    function automatic logic even_parity_err(input logic [CDC_DATA_W-1:0] data,
                                             input logic                  par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/cm0_dap_cdc_sync_ff.sv
// Reset-to-0 single-bit synchroniser; r_cdc_sync_cells are the CDC synchroniser cells.
module cm0_dap_cdc_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_cdc_sync_cells;

    // NOTE: non-blocking assignments make every stage sample the previous stage's old value,
    // so the chain shifts by one flop per edge instead of collapsing into a single flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cdc_sync_cells <= '0;
        end else begin
            r_cdc_sync_cells <= {r_cdc_sync_cells[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_cdc_sync_cells[STAGES-1];

endmodule

// File: rtl/cm0_dap_cdc_recv_ctrl.sv
// Receive-side controller for the 32-bit four-phase req/ack DAP data crossing.
// Optional parity checking is enabled by defining CM0_DAP_CDC_PARITY_EN.
module cm0_dap_cdc_recv_ctrl
    import cm0_dap_cdc_pkg::*;
#(
    parameter int PRESENT     = 1,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 1
) (
    input  logic                  SWCLKTCK,
    input  logic                  DPRESET,
    input  logic                  CDCREQ,
    input  logic [CDC_DATA_W-1:0] MASKEDDATA,
`ifdef CM0_DAP_CDC_PARITY_EN
    input  logic                  CDCPAR,
`endif
    output logic                  MASKn,
    output logic                  CDCACK,
    output logic [CDC_DATA_W-1:0] RDATA,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RDERR
);

    if (PRESENT != 0) begin : g_present

        cdc_state_e              r_state;
        cdc_state_e              w_state_nxt;
        logic [SETTLE_CNT_W-1:0] r_settle_cnt;
        logic                    r_maskn;
        logic                    r_cdcack;
        logic                    r_rvalid;
        logic [CDC_DATA_W-1:0]   r_rdata;
        logic                    w_reqs;
        logic                    w_open_done;
        logic                    w_buf_free;
        logic                    w_capture;
        logic                    w_pop;

        cm0_dap_cdc_sync_ff #(
            .STAGES (SYNC_STAGES)
        ) u_req_sync (
            .i_clk   (SWCLKTCK),
            .i_rst   (DPRESET),
            .i_async (CDCREQ),
            .o_sync  (w_reqs)
        );

        assign w_open_done = (r_settle_cnt == SETTLE_CNT_W'(SETTLE - 1));
        // A full buffer may still take a new request if the consumer drains it this cycle.
        assign w_buf_free  = !r_rvalid || RREADY;
        assign w_capture   = (r_state == OPEN) && w_open_done;
        assign w_pop       = r_rvalid && RREADY;

        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                IDLE:    if (w_reqs && w_buf_free) w_state_nxt = OPEN;
                OPEN:    if (w_open_done)          w_state_nxt = CAPT;
                CAPT:                              w_state_nxt = ACKHI;
                ACKHI:   if (!w_reqs)              w_state_nxt = ACKLO;
                ACKLO:                             w_state_nxt = IDLE;
                default:                           w_state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge SWCLKTCK) begin
            if (DPRESET) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Outputs are decoded from the next state so they are glitch-free flops that change
        // together with the state; MASKn and CDCACK are thereby mutually exclusive.
        always_ff @(posedge SWCLKTCK) begin
            if (DPRESET) begin
                r_settle_cnt <= '0;
                r_maskn      <= 1'b0;
                r_cdcack     <= 1'b0;
                r_rvalid     <= 1'b0;
                r_rdata      <= '0;
            end else begin
                r_maskn  <= (w_state_nxt == OPEN);
                r_cdcack <= (w_state_nxt == CAPT) || (w_state_nxt == ACKHI);
                if ((r_state == OPEN) && !w_open_done) begin
                    r_settle_cnt <= r_settle_cnt + SETTLE_CNT_W'(1);
                end else begin
                    r_settle_cnt <= '0;
                end
                if (w_capture) begin
                    r_rdata  <= MASKEDDATA;
                    r_rvalid <= 1'b1;
                end else if (w_pop) begin
                    r_rvalid <= 1'b0;
                end
            end
        end

`ifdef CM0_DAP_CDC_PARITY_EN
        logic r_rderr;

        always_ff @(posedge SWCLKTCK) begin
            if (DPRESET) begin
                r_rderr <= 1'b0;
            end else if (w_capture) begin
                r_rderr <= even_parity_err(MASKEDDATA, CDCPAR);
            end else if (w_pop) begin
                r_rderr <= 1'b0;
            end
        end

        assign RDERR = r_rderr;
`else
        assign RDERR = 1'b0;
`endif

        assign MASKn  = r_maskn;
        assign CDCACK = r_cdcack;
        assign RDATA  = r_rdata;
        assign RVALID = r_rvalid;

    end else begin : g_absent

`ifdef CM0_DAP_CDC_PARITY_EN
        logic w_unused_inputs;
        assign w_unused_inputs = ^{SWCLKTCK, DPRESET, CDCREQ, MASKEDDATA, RREADY, CDCPAR};
`else
        logic w_unused_inputs;
        assign w_unused_inputs = ^{SWCLKTCK, DPRESET, CDCREQ, MASKEDDATA, RREADY};
`endif

        assign MASKn  = 1'b0;
        assign CDCACK = 1'b0;
        assign RDATA  = '0;
        assign RVALID = 1'b0;
        assign RDERR  = 1'b0;

    end

endmodule

// File: tb/tb_cm0_dap_cdc_recv_ctrl.sv
// Self-checking bench for cm0_dap_cdc_recv_ctrl: sender model, AND mask model and scoreboard.
module tb_cm0_dap_cdc_recv_ctrl;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cdcreq = 1'b0;
    logic        cdcpar = 1'b0;
    logic        rready = 1'b0;
    logic [31:0] tx_data = '0;
    logic        maskn, cdcack, rvalid, rderr;
    logic [31:0] rdata;
    logic [31:0] masked;

    logic        req_b = 1'b0;
    logic [31:0] data_b = '0;
    logic        maskn_b, cdcack_b, rvalid_b, rderr_b;
    logic [31:0] rdata_b;
    logic [31:0] masked_b;

    logic        z_maskn, z_cdcack, z_rvalid, z_rderr;
    logic [31:0] z_rdata;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // AND mask in front of the receiver: data only reaches it while MASKn is high.
    assign masked   = tx_data & {32{maskn}};
    assign masked_b = data_b & {32{maskn_b}};

    cm0_dap_cdc_recv_ctrl dut (
        .SWCLKTCK   (clk),
        .DPRESET    (rst),
        .CDCREQ     (cdcreq),
        .MASKEDDATA (masked),
`ifdef CM0_DAP_CDC_PARITY_EN
        .CDCPAR     (cdcpar),
`endif
        .MASKn      (maskn),
        .CDCACK     (cdcack),
        .RDATA      (rdata),
        .RVALID     (rvalid),
        .RREADY     (rready),
        .RDERR      (rderr)
    );

    cm0_dap_cdc_recv_ctrl #(.SYNC_STAGES(3), .SETTLE(3)) dut_b (
        .SWCLKTCK   (clk),
        .DPRESET    (rst),
        .CDCREQ     (req_b),
        .MASKEDDATA (masked_b),
`ifdef CM0_DAP_CDC_PARITY_EN
        .CDCPAR     (1'b0),
`endif
        .MASKn      (maskn_b),
        .CDCACK     (cdcack_b),
        .RDATA      (rdata_b),
        .RVALID     (rvalid_b),
        .RREADY     (1'b1),
        .RDERR      (rderr_b)
    );

    cm0_dap_cdc_recv_ctrl #(.PRESENT(0)) dut_z (
        .SWCLKTCK   (clk),
        .DPRESET    (rst),
        .CDCREQ     (cdcreq),
        .MASKEDDATA (tx_data),
`ifdef CM0_DAP_CDC_PARITY_EN
        .CDCPAR     (cdcpar),
`endif
        .MASKn      (z_maskn),
        .CDCACK     (z_cdcack),
        .RDATA      (z_rdata),
        .RVALID     (z_rvalid),
        .RREADY     (rready),
        .RDERR      (z_rderr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] d, input logic p);
`ifdef CM0_DAP_CDC_PARITY_EN
        return ^{d, p};
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (cdcack !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'b0, cdcack}, {31'b0, lvl});
    endtask

    task automatic push_exp(input logic [31:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.err  = exp_err(d, p);
        sb_q.push_back(e);
    endtask

    // Full four-phase transfer from the sender's side.
    task automatic send(input logic [31:0] d, input logic p);
        push_exp(d, p);
        tx_data = d;
        cdcpar  = p;
        cdcreq  = 1'b1;
        wait_ack(1'b1, 400, "ack_rise_timeout");
        cdcreq  = 1'b0;
        wait_ack(1'b0, 50, "ack_fall_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, rdata | {27'b0, maskn, cdcack, rvalid, rderr, 1'b0}, 32'h0);
    endtask

    // Monitor: protocol invariant, absent instance, and in-order scoreboard on every accept.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("mask_ack_excl", {31'b0, maskn & cdcack}, 32'h0);
            check("absent_outs", z_rdata | {28'b0, z_maskn, z_cdcack, z_rvalid, z_rderr}, 32'h0);
            if (rvalid && rready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", rdata, 32'hxxxx_xxxx);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", rdata, e.data);
                    check("sb_rderr", {31'b0, rderr}, {31'b0, e.err});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          mcnt;
        logic [31:0] rd;
        logic        rp;
        bit          done;

        // Reset values
        repeat (3) tick();
        check_all_zero("reset_outs");
        check("reset_outs_b", rdata_b | {29'b0, maskn_b, cdcack_b, rvalid_b}, 32'h0);
        rst = 1'b0;
        tick();

        // Default latency and ACK release
        rready = 1'b1;
        push_exp(32'hDEAD_BEEF, ^32'hDEAD_BEEF);
        tx_data = 32'hDEAD_BEEF;
        cdcpar  = ^32'hDEAD_BEEF;
        cdcreq  = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        check("latency_default", n, 4);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_ack", {31'b0, cdcack}, 32'h1);
        check("t1_mask_closed", {31'b0, maskn}, 32'h0);
        cdcreq = 1'b0;
        n = 0;
        while (cdcack && n < 20) begin
            tick();
            n++;
        end
        check("ack_fall_delay", n, 3);
        tick();
        check("t1_rvalid_cleared", {31'b0, rvalid}, 32'h0);

        // Back-to-back with a full buffer: second request is held off
        rready = 1'b0;
        send(32'h1, 1'b1);
        check("t2_first_valid", {31'b0, rvalid}, 32'h1);
        push_exp(32'h2, 1'b1);
        tx_data = 32'h2;
        cdcpar  = 1'b1;
        cdcreq  = 1'b1;
        repeat (8) begin
            tick();
            check("t2_held_mask", {31'b0, maskn}, 32'h0);
            check("t2_held_ack", {31'b0, cdcack}, 32'h0);
            check("t2_rdata_stable", rdata, 32'h1);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        wait_ack(1'b1, 20, "t2_second_ack");
        check("t2_rdata_second", rdata, 32'h2);
        check("t2_rvalid_second", {31'b0, rvalid}, 32'h1);
        cdcreq = 1'b0;
        wait_ack(1'b0, 20, "t2_second_ack_fall");
        repeat (4) begin
            tick();
            check("t2_rdata_hold", rdata, 32'h2);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        tick();
        check("t2_no_duplicate", {31'b0, rvalid}, 32'h0);
        check("t2_sb_empty", sb_q.size(), 0);

        // Reset while the mask is open
        rready  = 1'b1;
        tx_data = 32'hA5A5_0F0F;
        cdcreq  = 1'b1;
        n = 0;
        while (!maskn && n < 20) begin
            tick();
            n++;
        end
        check("t3_open_reached", {31'b0, maskn}, 32'h1);
        rst    = 1'b1;
        cdcreq = 1'b0;
        tick();
        check_all_zero("t3_reset_in_open");
        rst = 1'b0;
        tick();

        // Reset while ACK is held high
        rready  = 1'b0;
        tx_data = 32'h55AA_33CC;
        cdcreq  = 1'b1;
        wait_ack(1'b1, 20, "t3_ackhi_reached");
        tick();
        check("t3_ack_held", {31'b0, cdcack}, 32'h1);
        rst    = 1'b1;
        cdcreq = 1'b0;
        tick();
        check_all_zero("t3_reset_in_ackhi");
        rst = 1'b0;
        tick();
        rready = 1'b1;
        send(32'h1234_5678, ^32'h1234_5678);
        repeat (3) tick();
        check("t3_recovered", sb_q.size(), 0);

        // Random transfers against a randomly stalling consumer
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    rd = $urandom;
                    rp = 1'($urandom_range(0, 1));
                    send(rd, rp);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    rready = 1'($urandom_range(0, 1));
                end
            end
        join
        rready = 1'b1;
        repeat (5) tick();
        check("t4_drained", sb_q.size(), 0);
        check("t4_rvalid_idle", {31'b0, rvalid}, 32'h0);

        // Deep synchroniser and long settle
        data_b = 32'hCAFE_F00D;
        req_b  = 1'b1;
        n = 0;
        mcnt = 0;
        while (!rvalid_b && n < 30) begin
            tick();
            n++;
            if (maskn_b) mcnt++;
        end
        check("latency_3_3", n, 7);
        check("t5_settle_cycles", mcnt, 3);
        check("t5_rdata", rdata_b, 32'hCAFE_F00D);
        check("t5_mask_ack_excl", {31'b0, maskn_b & cdcack_b}, 32'h0);
        req_b = 1'b0;
        repeat (6) tick();
        check("t5_ack_released", {31'b0, cdcack_b}, 32'h0);

        // Parity flag on a single-bit word
        rready = 1'b0;
        send(32'h0000_0001, 1'b0);
        check("t6_rvalid", {31'b0, rvalid}, 32'h1);
        check("t6_rderr_bad", {31'b0, rderr}, {31'b0, exp_err(32'h1, 1'b0)});
        rready = 1'b1;
        tick();
        rready = 1'b0;
        tick();
        check("t6_rderr_cleared", {31'b0, rderr}, 32'h0);
        send(32'h0000_0001, 1'b1);
        check("t6_rderr_good", {31'b0, rderr}, {31'b0, exp_err(32'h1, 1'b1)});
        rready = 1'b1;
        repeat (3) tick();
        check("final_sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
